// File: rtl/sw_debounce_edge.sv
// Slide-switch conditioner: per-switch 2-flop synchronizer, stable-count
// debouncer and registered rising/falling edge pulses.
module sw_debounce_edge #(
  parameter int NUM_SW          = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] sw_in,
  output logic [NUM_SW-1:0] sw_level,
  output logic [NUM_SW-1:0] sw_rise,
  output logic [NUM_SW-1:0] sw_fall,
  output logic              any_rise
);

  // Counter just wide enough to hold the terminal value DEBOUNCE_CYCLES-1.
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_SW-1:0] sync_a;
  logic [NUM_SW-1:0] sync;
  logic [NUM_SW-1:0] deb;
  logic [NUM_SW-1:0] deb_next;
  logic [CW-1:0]     cnt      [NUM_SW];
  logic [CW-1:0]     cnt_next [NUM_SW];
  logic [NUM_SW-1:0] rise_next;
  logic [NUM_SW-1:0] fall_next;

  // Two-stage synchronizer; only the second stage is used downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync   <= '0;
    end else begin
      sync_a <= sw_in;
      sync   <= sync_a;
    end
  end

  // Per-switch qualification: any disagreement-free cycle restarts the count,
  // and the stable level only moves once the count reaches its terminal value.
  always_comb begin
    deb_next = deb;
    for (int i = 0; i < NUM_SW; i++) begin
      cnt_next[i] = '0;
      if (sync[i] != deb[i]) begin
        if (cnt[i] == TERM) begin
          deb_next[i] = sync[i];
          cnt_next[i] = '0;
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // Stable-level and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb <= '0;
      for (int i = 0; i < NUM_SW; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      deb <= deb_next;
      for (int i = 0; i < NUM_SW; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  // Edge detect between deb and the registered level, so a pulse coincides
  // with the first cycle the new level is visible on sw_level.
  always_comb begin
    rise_next = deb & ~sw_level;
    fall_next = ~deb & sw_level;
  end

  // Registered outputs; pulses last exactly one cycle because sw_level
  // catches up with deb at the same edge the pulse is raised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_level <= '0;
      sw_rise  <= '0;
      sw_fall  <= '0;
      any_rise <= 1'b0;
    end else begin
      sw_level <= deb;
      sw_rise  <= rise_next;
      sw_fall  <= fall_next;
      any_rise <= |rise_next;
    end
  end

endmodule

// File: tb/tb_sw_debounce_edge.sv
// Directed bench for sw_debounce_edge with DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sw_debounce_edge;

  logic       clk;
  logic       rst;
  logic [9:0] sw_in;
  logic [9:0] sw_level;
  logic [9:0] sw_rise;
  logic [9:0] sw_fall;
  logic       any_rise;

  int compared   = 0;
  int mismatched = 0;
  int pulseCount;

  sw_debounce_edge #(
    .NUM_SW          (10),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_in    (sw_in),
    .sw_level (sw_level),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .any_rise (any_rise)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One rising edge passes; returns on the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive new switch levels on the current falling edge.
  task automatic applyStimulus(input logic [9:0] value);
    sw_in = value;
  endtask

  // Check all four outputs in one go.
  task automatic checkAll(input string tag, input logic [9:0] lvl,
                          input logic [9:0] ris, input logic [9:0] fal);
    checkOutput({tag, ".level"}, 32'(sw_level), 32'(lvl));
    checkOutput({tag, ".rise"},  32'(sw_rise),  32'(ris));
    checkOutput({tag, ".fall"},  32'(sw_fall),  32'(fal));
    checkOutput({tag, ".any"},   32'(any_rise), 32'(|ris));
  endtask

  initial begin
    rst   = 1'b1;
    sw_in = '0;
    #1;
    checkAll("reset", 10'h000, 10'h000, 10'h000);
    tick(3);
    rst = 1'b0;
    tick(3);
    checkAll("idle", 10'h000, 10'h000, 10'h000);

    // Single rise on switch 2: visible after the 7th edge following the change.
    applyStimulus(10'b0000000100);
    tick(6);
    checkAll("sw2_pre", 10'h000, 10'h000, 10'h000);
    tick(1);
    checkAll("sw2_rise", 10'b0000000100, 10'b0000000100, 10'h000);
    tick(1);
    checkAll("sw2_after", 10'b0000000100, 10'h000, 10'h000);

    // Held high for 100 more cycles: no further pulse.
    pulseCount = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (sw_rise[2]) pulseCount++;
    end
    checkOutput("sw2_hold_pulses", 32'(pulseCount), 32'd0);

    // Bounce on switch 0: high 3, low 1, then steady high.
    pulseCount = 0;
    applyStimulus(10'b0000000101);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (sw_rise[0]) pulseCount++;
    end
    applyStimulus(10'b0000000100);
    tick(1);
    if (sw_rise[0]) pulseCount++;
    applyStimulus(10'b0000000101);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (sw_rise[0]) pulseCount++;
    end
    checkOutput("bounce_no_early", 32'(pulseCount), 32'd0);
    checkAll("bounce_pre", 10'b0000000100, 10'h000, 10'h000);
    tick(1);
    checkAll("bounce_rise", 10'b0000000101, 10'b0000000001, 10'h000);
    tick(1);
    checkAll("bounce_after", 10'b0000000101, 10'h000, 10'h000);

    // Switches 1 and 6 rise together.
    applyStimulus(10'b0001000111);
    tick(6);
    checkAll("pair_pre", 10'b0000000101, 10'h000, 10'h000);
    tick(1);
    checkAll("pair_rise", 10'b0001000111, 10'b0001000010, 10'h000);
    tick(1);
    checkAll("pair_after", 10'b0001000111, 10'h000, 10'h000);

    // Switch 2 falls.
    applyStimulus(10'b0001000011);
    tick(6);
    checkAll("sw2fall_pre", 10'b0001000111, 10'h000, 10'h000);
    tick(1);
    checkAll("sw2fall", 10'b0001000011, 10'h000, 10'b0000000100);
    tick(1);
    checkAll("sw2fall_after", 10'b0001000011, 10'h000, 10'h000);

    // Switch 5 high through reset is qualified as a fresh rise.
    rst = 1'b1;
    applyStimulus(10'b0000100000);
    #1;
    checkAll("rst_async", 10'h000, 10'h000, 10'h000);
    tick(3);
    rst = 1'b0;
    tick(6);
    checkAll("sw5_pre", 10'h000, 10'h000, 10'h000);
    tick(1);
    checkAll("sw5_rise", 10'b0000100000, 10'b0000100000, 10'h000);
    tick(1);
    checkAll("sw5_after", 10'b0000100000, 10'h000, 10'h000);

    // Reset during switch 3 qualification (counter at 2) discards it.
    applyStimulus(10'b0000101000);
    tick(4);
    checkAll("sw3_mid", 10'b0000100000, 10'h000, 10'h000);
    rst = 1'b1;
    #1;
    checkAll("rst_mid", 10'h000, 10'h000, 10'h000);
    tick(1);
    rst = 1'b0;
    tick(6);
    checkAll("requal_pre", 10'h000, 10'h000, 10'h000);
    tick(1);
    checkAll("requal_rise", 10'b0000101000, 10'b0000101000, 10'h000);
    tick(1);
    checkAll("requal_after", 10'b0000101000, 10'h000, 10'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sw_debounce_edge.md
SW_DEBOUNCE_EDGE -- requirements
Module: sw_debounce_edge

Interface
REQ-001 Parameter: NUM_SW, default 10, number of switch inputs.
REQ-002 Parameter: DEBOUNCE_CYCLES, default 500000, consecutive stable cycles needed to accept a new level (10 ms at 50 MHz); legal range 2..2^24.
REQ-003 Port: clk  input  1  single system clock; all state on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: sw_in  input  NUM_SW  raw asynchronous slide-switch levels.
REQ-006 Port: sw_level  output  NUM_SW  debounced switch level, registered.
REQ-007 Port: sw_rise  output  NUM_SW  one-cycle pulse per accepted 0->1 transition, registered; drives the password FSM's sw_rise input.
REQ-008 Port: sw_fall  output  NUM_SW  one-cycle pulse per accepted 1->0 transition, registered.
REQ-009 Port: any_rise  output  1  registered OR of all sw_rise bits, same cycle as sw_rise.

Function
REQ-010 Each sw_in bit SHALL pass through a 2-flop synchronizer; only the second flop output (sync) feeds downstream logic.
REQ-011 Each switch SHALL have an independent counter of width clog2(DEBOUNCE_CYCLES), plus a stable-level register deb driving sw_level.
REQ-012 If sync == deb in a cycle, that switch's counter SHALL clear to 0 at the next edge.
REQ-013 If sync != deb and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-014 If sync != deb and counter == DEBOUNCE_CYCLES-1, deb SHALL load sync and the counter SHALL clear to 0 at that edge.
REQ-015 Any single cycle where sync returns to deb (bounce) SHALL clear the counter; qualification restarts from 0, no partial credit.
REQ-016 sw_rise[i] SHALL be 1 exactly in the cycle after the edge where deb[i] loads 1 from 0, i.e. concurrent with sw_level[i] first reading 1; 0 otherwise.
REQ-017 sw_fall[i] SHALL behave identically for deb[i] loading 0 from 1.
REQ-018 Latency: sw_in[i] changing before edge 0 and held stable SHALL cause sw_level[i]/pulse to appear after edge 2+DEBOUNCE_CYCLES.
REQ-019 A pulse SHALL last exactly one cycle regardless of how long the switch stays at the new level; no re-trigger without an accepted opposite transition.
REQ-020 Switches SHALL be fully independent; several sw_rise bits MAY assert in the same cycle, and the block SHALL NOT arbitrate or suppress them.
REQ-021 any_rise SHALL equal the OR of sw_rise in every cycle.
REQ-022 Counters SHALL never wrap; the terminal value DEBOUNCE_CYCLES-1 is the maximum reached.

Reset
REQ-023 While rst is 1, synchronizer flops, deb, counters, sw_level, sw_rise, sw_fall and any_rise SHALL all be 0, asynchronously.
REQ-024 After rst deasserts, a switch already high SHALL be qualified as a normal 0->1 transition and produce one sw_rise pulse at edge 2+DEBOUNCE_CYCLES after release.
REQ-025 rst asserted mid-qualification SHALL discard the count; no pulse SHALL be emitted for that transition until it requalifies after release.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 sw_in[2] 0->1 before edge 0, held -> sw_level[2]=1 and sw_rise[2]=1 after edge 6, sw_rise[2]=0 after edge 7, sw_fall all 0.
REQ-027 sw_in[0] high 3 sync cycles, low 1, then high steady -> no pulse during bounce; sw_rise[0] only 4 cycles after final stable sync, exactly once.
REQ-028 sw_in[1] and sw_in[6] rise in same cycle -> sw_rise = 10'b0001000010 for one cycle, any_rise=1 that cycle only.
REQ-029 sw_level[2]=1 then sw_in[2] 1->0 held -> sw_fall[2] one-cycle pulse after 6 edges, sw_rise[2] stays 0.
REQ-030 sw_in[5] high during reset, rst released -> single sw_rise[5] pulse 6 edges after release; rst pulsed at counter=2 of a pending rise -> outputs 0 immediately, pulse only after full requalification.
REQ-031 Switch held high 100 cycles after qualification -> exactly one sw_rise pulse total; counter never exceeds 3.
